uart_rx_oversampled: RTL and testbench
======================================

UART_RX_OVERSAMPLED -- requirements
Module: uart_rx_oversampled

Interface
REQ-001 The block SHALL have parameter CLK_FREQ, default 1000000, meaning clk frequency in Hz.
REQ-002 The block SHALL have parameter BAUD_RATE, default 9600, meaning serial bit rate in bit/s.
REQ-003 The block SHALL have derived constant DIV = CLK_FREQ/(BAUD_RATE*16), integer division, meaning clk cycles per oversample tick; DIV SHALL be at least 2.
REQ-004 The block SHALL have port clk, input, 1 bit: single clock for all logic; no derived clocks.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-006 The block SHALL have port rx, input, 1 bit: asynchronous serial line, idle high.
REQ-007 The block SHALL have port rx_data, output, 8 bits: received byte, valid while rx_valid=1.
REQ-008 The block SHALL have port rx_valid, output, 1 bit: rx_data holds an unconsumed byte.
REQ-009 The block SHALL have port rx_ready, input, 1 bit: consumer accepts the byte when rx_valid=1 and rx_ready=1.
REQ-010 The block SHALL have port frame_err, output, 1 bit: one-clk pulse when the stop bit samples 0.
REQ-011 The block SHALL have port overrun, output, 1 bit: one-clk pulse when a byte is lost because the holding register is full.

Function
REQ-012 rx SHALL pass through a 2-flop synchronizer (rx_s); all sampling SHALL use rx_s.
REQ-013 The tick counter SHALL count 0..DIV-1 and pulse tick for one clk at DIV-1, then wrap to 0; the counter SHALL free-run in all states.
REQ-014 The FSM SHALL have exactly 5 states: IDLE, START, DATA, STOP, RECOVER; all state and counter updates SHALL occur only on tick cycles, except handshake logic, which SHALL run every clk.
REQ-015 In IDLE, on a tick with rx_s=0, the FSM SHALL go to START and clear the 4-bit sample counter.
REQ-016 In START, at the 8th tick (mid start bit), rx_s=0 SHALL move to DATA with the sample and bit counters cleared; rx_s=1 SHALL be treated as a glitch and return to IDLE with no output.
REQ-017 In DATA, every 16th tick SHALL sample rx_s into the shift register, LSB first; after the 8th bit the FSM SHALL go to STOP.
REQ-018 In STOP, at the 16th tick, rx_s=1 SHALL deliver the byte (REQ-020) and go to IDLE.
REQ-019 In STOP, at the 16th tick, rx_s=0 SHALL discard the byte, pulse frame_err for 1 clk, and go to RECOVER; RECOVER SHALL return to IDLE on the first tick with rx_s=1.
REQ-020 Delivery SHALL occur in the clk after the stop-bit sampling tick:
  - if rx_valid=0, or rx_valid=1 and rx_ready=1 in that clk: load rx_data and set rx_valid=1;
  - otherwise: keep the old rx_data, keep rx_valid=1, drop the new byte, and pulse overrun for 1 clk.
REQ-021 rx_valid SHALL clear in the clk after rx_valid=1 and rx_ready=1, unless a delivery occurs in the same clk.
REQ-022 rx_data SHALL remain stable while rx_valid=1.
REQ-023 A break (line held low, data 0x00, stop bit 0) SHALL produce exactly one frame_err, no rx_valid, and no new start until rx_s returns high.

Reset
REQ-024 On rst=1 at a clk edge, the block SHALL set FSM=IDLE, clear tick/sample/bit counters and the shift register, and set synchronizer flops to 1.
REQ-025 On rst=1 at a clk edge, outputs SHALL be: rx_data=0x00, rx_valid=0, frame_err=0, overrun=0.
REQ-026 rst asserted mid-frame SHALL abort the frame with no delivery and no error pulse; after release, reception SHALL restart only on a new falling edge.

Verification
(Parameters: CLK_FREQ=1600000, BAUD_RATE=10000, so DIV=10 and 1 bit = 160 clk.)
REQ-027 Bench SHALL drive byte 0xA5 (start 0, LSB first, stop 1) with rx_ready=1 -> rx_valid=1 for 1 clk, rx_data=0xA5, frame_err=0, overrun=0.
REQ-028 Bench SHALL drive 0x3C then 0xC3 back to back with rx_ready=0 -> rx_data=0x3C held, overrun pulses once at the second delivery; after rx_ready=1, rx_valid clears.
REQ-029 Bench SHALL drive 0x55 with stop bit 0, then rx high -> frame_err pulses once, rx_valid stays 0, FSM reaches IDLE; a following 0x0F is received correctly.
REQ-030 Bench SHALL drive a 40-clk low glitch on idle rx -> no rx_valid and no frame_err; FSM returns to IDLE.
REQ-031 Bench SHALL drive rx low for 12 bit times then high -> exactly one frame_err, no rx_valid; a following 0x81 is received correctly.
REQ-032 Bench SHALL assert rst for 1 clk during bit 4 of 0xFF -> all outputs 0 and no delivery; a subsequent 0x42 is received correctly.

Source files
------------

// File: rtl/uart_rx_oversampled.sv
// 8N1 UART receiver with 16x oversampling, start-bit glitch rejection and a
// single-entry valid/ready holding register with frame-error and overrun pulses.
module uart_rx_oversampled #(
   parameter int unsigned CLK_FREQ  = 1000000,
   parameter int unsigned BAUD_RATE = 9600
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       frame_err,
   output logic       overrun
);

   localparam int unsigned DIV = CLK_FREQ / (BAUD_RATE * 16);
   localparam int unsigned TW  = (DIV > 2) ? $clog2(DIV) : 1;

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_START   = 3'd1;
   localparam logic [2:0] S_DATA    = 3'd2;
   localparam logic [2:0] S_STOP    = 3'd3;
   localparam logic [2:0] S_RECOVER = 3'd4;

   logic          rx_meta_q, rx_s_q;
   logic [TW-1:0] tick_cnt_q;
   logic          tick;
   logic [2:0]    state_q, state_d;
   logic [3:0]    samp_q, samp_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic          deliver_q, deliver_d;
   logic          ferr_q, ferr_d;
   logic [7:0]    data_q;
   logic          valid_q;
   logic          overrun_q;

   assign tick = (tick_cnt_q == TW'(DIV - 1));

   always_comb begin
      state_d   = state_q;
      samp_d    = samp_q;
      bit_d     = bit_q;
      shift_d   = shift_q;
      deliver_d = 1'b0;
      ferr_d    = 1'b0;
      if (tick) begin
         case (state_q)
            S_IDLE: begin
               if (!rx_s_q) begin
                  state_d = S_START;
                  samp_d  = '0;
               end
            end
            S_START: begin
               // 8th tick after the falling edge lands mid start bit
               if (samp_q == 4'd7) begin
                  if (!rx_s_q) begin
                     state_d = S_DATA;
                     samp_d  = '0;
                     bit_d   = '0;
                  end else begin
                     state_d = S_IDLE;
                  end
               end else begin
                  samp_d = samp_q + 4'd1;
               end
            end
            S_DATA: begin
               samp_d = samp_q + 4'd1;
               if (samp_q == 4'd15) begin
                  shift_d = {rx_s_q, shift_q[7:1]};
                  bit_d   = bit_q + 3'd1;
                  if (bit_q == 3'd7) state_d = S_STOP;
               end
            end
            S_STOP: begin
               samp_d = samp_q + 4'd1;
               if (samp_q == 4'd15) begin
                  if (rx_s_q) begin
                     deliver_d = 1'b1;
                     state_d   = S_IDLE;
                  end else begin
                     ferr_d  = 1'b1;
                     state_d = S_RECOVER;
                  end
               end
            end
            S_RECOVER: begin
               if (rx_s_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta_q  <= 1'b1;
         rx_s_q     <= 1'b1;
         tick_cnt_q <= '0;
         state_q    <= S_IDLE;
         samp_q     <= '0;
         bit_q      <= '0;
         shift_q    <= '0;
         deliver_q  <= 1'b0;
         ferr_q     <= 1'b0;
      end else begin
         rx_meta_q  <= rx;
         rx_s_q     <= rx_meta_q;
         tick_cnt_q <= tick ? '0 : tick_cnt_q + TW'(1);
         state_q    <= state_d;
         samp_q     <= samp_d;
         bit_q      <= bit_d;
         shift_q    <= shift_d;
         deliver_q  <= deliver_d;
         ferr_q     <= ferr_d;
      end
   end

   // Holding register: shift_q is untouched in IDLE, so it still carries the byte here
   always_ff @(posedge clk) begin
      if (rst) begin
         data_q    <= '0;
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         overrun_q <= 1'b0;
         if (deliver_q) begin
            if (!valid_q || rx_ready) begin
               data_q  <= shift_q;
               valid_q <= 1'b1;
            end else begin
               overrun_q <= 1'b1;
            end
         end else if (valid_q && rx_ready) begin
            valid_q <= 1'b0;
         end
      end
   end

   assign rx_data   = data_q;
   assign rx_valid  = valid_q;
   assign frame_err = ferr_q;
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Self-checking bench for uart_rx_oversampled: directed corner frames plus
// random 8N1 traffic compared against a frame-level reference model.
`timescale 1ns/1ps
module tb_uart_rx_oversampled;

   localparam int unsigned BIT_CLKS = 160;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx = 1'b1;
   logic       rx_ready = 1'b1;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       frame_err;
   logic       overrun;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   // observed by the monitor
   byte unsigned acc_q[$];
   int unsigned  fe_seen = 0;
   int unsigned  ov_seen = 0;
   int unsigned  vld_cycles = 0;
   int unsigned  stab_viol = 0;
   logic         prev_valid = 1'b0;
   logic [7:0]   prev_data = '0;

   // reference model state
   byte unsigned exp_q[$];
   int unsigned  exp_fe = 0;
   int unsigned  exp_ov = 0;
   bit           model_full = 1'b0;
   byte unsigned model_byte = 0;
   int unsigned  cmp_idx = 0;

   always #5 clk = ~clk;

   uart_rx_oversampled #(
      .CLK_FREQ (1600000),
      .BAUD_RATE(10000)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .rx       (rx),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .rx_ready (rx_ready),
      .frame_err(frame_err),
      .overrun  (overrun)
   );

   always @(negedge clk) begin
      if (rx_valid && rx_ready) acc_q.push_back(rx_data);
      if (frame_err) fe_seen++;
      if (overrun) ov_seen++;
      if (rx_valid) vld_cycles++;
      if (prev_valid && rx_valid && (rx_data != prev_data)) stab_viol++;
      prev_valid = rx_valid;
      prev_data  = rx_data;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic hold(input int unsigned n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // One 8N1 frame as the line would carry it.
   task automatic send_frame(input logic [7:0] d, input logic stop);
      rx = 1'b0;
      hold(BIT_CLKS);
      for (int i = 0; i < 8; i++) begin
         rx = d[i];
         hold(BIT_CLKS);
      end
      rx = stop;
      hold(BIT_CLKS);
      rx = 1'b1;
   endtask

   // Frame-level outcome: a good stop bit offers the byte to a one-deep buffer.
   function automatic void model_frame(input byte unsigned d, input bit stop);
      if (!stop) exp_fe++;
      else if (model_full) exp_ov++;
      else if (rx_ready) exp_q.push_back(d);
      else begin
         model_full = 1'b1;
         model_byte = d;
      end
   endfunction

   function automatic void model_release();
      if (model_full) begin
         exp_q.push_back(model_byte);
         model_full = 1'b0;
      end
   endfunction

   task automatic finish_scn(input string tag);
      hold(200);
      check({tag, " bytes"}, acc_q.size(), exp_q.size());
      for (int i = int'(cmp_idx); i < exp_q.size(); i++)
         check({tag, " data"}, (i < acc_q.size()) ? 32'(acc_q[i]) : 32'hDEAD, 32'(exp_q[i]));
      cmp_idx = exp_q.size();
      check({tag, " frame_err"}, fe_seen, exp_fe);
      check({tag, " overrun"}, ov_seen, exp_ov);
      check({tag, " stable"}, stab_viol, 0);
   endtask

   initial begin
      int unsigned v0;
      logic [7:0]  d;
      bit          stop;

      hold(4);
      check("reset rx_valid", rx_valid, 0);
      check("reset rx_data", rx_data, 0);
      check("reset frame_err", frame_err, 0);
      check("reset overrun", overrun, 0);
      rst = 1'b0;
      hold(50);

      // single byte, consumer ready
      v0 = vld_cycles;
      model_frame(8'hA5, 1);
      send_frame(8'hA5, 1'b1);
      finish_scn("a5");
      check("a5 valid_cycles", vld_cycles - v0, 1);

      // back to back with consumer stalled
      rx_ready = 1'b0;
      model_frame(8'h3C, 1);
      model_frame(8'hC3, 1);
      send_frame(8'h3C, 1'b1);
      send_frame(8'hC3, 1'b1);
      hold(40);
      check("stall rx_valid", rx_valid, 1);
      check("stall rx_data", rx_data, 8'h3C);
      rx_ready = 1'b1;
      model_release();
      hold(2);
      check("stall drained", rx_valid, 0);
      finish_scn("stall");

      // bad stop bit, then a clean frame
      model_frame(8'h55, 0);
      send_frame(8'h55, 1'b0);
      finish_scn("badstop");
      model_frame(8'h0F, 1);
      send_frame(8'h0F, 1'b1);
      finish_scn("after_badstop");

      // short low glitch on an idle line
      rx = 1'b0;
      hold(40);
      rx = 1'b1;
      hold(400);
      finish_scn("glitch");

      // break: 12 bit times low
      exp_fe++;
      rx = 1'b0;
      hold(12 * BIT_CLKS);
      rx = 1'b1;
      hold(300);
      finish_scn("break");
      model_frame(8'h81, 1);
      send_frame(8'h81, 1'b1);
      finish_scn("after_break");

      // reset pulse in bit 4 of 0xFF
      rx = 1'b0;
      hold(BIT_CLKS);
      for (int i = 0; i < 4; i++) begin
         rx = 1'b1;
         hold(BIT_CLKS);
      end
      hold(BIT_CLKS / 2);
      rst = 1'b1;
      hold(1);
      check("midrst rx_valid", rx_valid, 0);
      check("midrst rx_data", rx_data, 0);
      check("midrst frame_err", frame_err, 0);
      check("midrst overrun", overrun, 0);
      rst = 1'b0;
      hold(BIT_CLKS / 2 + 4 * BIT_CLKS);
      finish_scn("midrst");
      model_frame(8'h42, 1);
      send_frame(8'h42, 1'b1);
      finish_scn("after_midrst");

      // random traffic
      for (int n = 0; n < 16; n++) begin
         d    = 8'($urandom_range(0, 255));
         stop = ($urandom_range(0, 3) != 0);
         model_frame(d, stop);
         send_frame(d, stop);
         if (stop) hold($urandom_range(0, 200));
         else hold(BIT_CLKS + $urandom_range(0, 200));
      end
      finish_scn("random");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
